// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
//   REQ_A / REQ_B : requester encodings, identical to the write-data mux select
//   REG_ZERO      : architectural zero register index (writes are dropped)
//   grant_e       : last-grant state of the round-robin arbiter
package wb_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic REQ_A = 1'b1;
  localparam logic REQ_B = 1'b0;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    GNT_B = REQ_B,
    GNT_A = REQ_A
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant.
//   a_valid, b_valid : requests
//   last_grant       : requester granted most recently
//   gnt_a, gnt_b     : one-hot-or-zero grant
// FIXED_PRIO != 0 makes A win every conflict; otherwise the requester that
// did not win last time gets the conflict.
module rr_arbiter2
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   a_valid,
  input  logic   b_valid,
  input  grant_e last_grant,
  output logic   gnt_a,
  output logic   gnt_b
);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_valid && b_valid) begin
      if ((FIXED_PRIO != 0) || (last_grant == GNT_B)) gnt_a = 1'b1;
      else                                            gnt_b = 1'b1;
    end else begin
      gnt_a = a_valid;
      gnt_b = b_valid;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU stage (A) and the
// multi-cycle unit (B).
//   a_* / b_*      : valid/ready write requests (rd + data)
//   sel            : registered write-data mux select, 1 = A, 0 = B
//   wr_en/addr/data: registered write port, one cycle after the grant
//   conflict_cnt   : saturating count of cycles with both requests valid
//   clr_cnt        : synchronous clear of conflict_cnt (wins over increment)
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_cnt,
  input  logic              clr_cnt
);

  grant_e            last_grant_q, last_grant_d;
  logic              gnt_a, gnt_b, any_gnt;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .last_grant(last_grant_q),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b)
  );

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign any_gnt  = gnt_a | gnt_b;
  assign win_rd   = gnt_a ? a_rd   : b_rd;
  assign win_data = gnt_a ? a_data : b_data;

  // Round-robin state: reset to B so that A takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GNT_B;
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_a)      last_grant_d = GNT_A;
    else if (gnt_b) last_grant_d = GNT_B;
  end

  // Output stage. A grant to x0 is still consumed and still loads addr/data,
  // it just never raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= REQ_B;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_gnt && (win_rd != ADDR_W'(REG_ZERO));
      if (any_gnt) begin
        sel     <= gnt_a ? REQ_A : REQ_B;
        wr_addr <= win_rd;
        wr_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          conflict_cnt <= '0;
    else if (clr_cnt)                                    conflict_cnt <= '0;
    else if (a_valid && b_valid && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        av = 1'b0, bv = 1'b0, clr = 1'b0;
  logic [4:0]  ard = '0, brd = '0;
  logic [31:0] ad = '0, bd = '0;

  // two instances share stimulus: round-robin with a 4-bit counter, fixed priority with 16 bits
  logic        rr_ar, rr_br, rr_sel, rr_wen, fp_ar, fp_br, fp_sel, fp_wen;
  logic [4:0]  rr_addr, fp_addr;
  logic [31:0] rr_data, fp_data;
  logic [3:0]  rr_cnt;
  logic [15:0] fp_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIXED_PRIO(0), .CNT_W(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av), .a_rd(ard), .a_data(ad), .a_ready(rr_ar),
    .b_valid(bv), .b_rd(brd), .b_data(bd), .b_ready(rr_br),
    .sel(rr_sel), .wr_en(rr_wen), .wr_addr(rr_addr), .wr_data(rr_data),
    .conflict_cnt(rr_cnt), .clr_cnt(clr));

  wb_port_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av), .a_rd(ard), .a_data(ad), .a_ready(fp_ar),
    .b_valid(bv), .b_rd(brd), .b_data(bd), .b_ready(fp_br),
    .sel(fp_sel), .wr_en(fp_wen), .wr_addr(fp_addr), .wr_data(fp_data),
    .conflict_cnt(fp_cnt), .clr_cnt(clr));

  logic        o_ar[2], o_br[2], o_sel[2], o_wen[2];
  logic [4:0]  o_addr[2];
  logic [31:0] o_data[2];
  logic [15:0] o_cnt[2];
  assign o_ar[0] = rr_ar;   assign o_ar[1] = fp_ar;
  assign o_br[0] = rr_br;   assign o_br[1] = fp_br;
  assign o_sel[0] = rr_sel; assign o_sel[1] = fp_sel;
  assign o_wen[0] = rr_wen; assign o_wen[1] = fp_wen;
  assign o_addr[0] = rr_addr; assign o_addr[1] = fp_addr;
  assign o_data[0] = rr_data; assign o_data[1] = fp_data;
  assign o_cnt[0] = {12'd0, rr_cnt}; assign o_cnt[1] = fp_cnt;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, what lands on it, how many conflicts seen.
  string       nm[2]    = '{"rr", "fp"};
  int          cmax[2]  = '{15, 65535};
  bit          fixed[2] = '{1'b0, 1'b1};
  bit          m_last_a[2];            // 1 = A won most recently
  bit          m_sel[2], m_wen[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_cnt[2];
  int          gsave[2];
  logic        ra, rb;                 // rr readies seen in the last cycle

  // 0 = nobody, 1 = A, 2 = B
  function automatic int winner(int k);
    if (av && bv) return (fixed[k] || !m_last_a[k]) ? 1 : 2;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last_a[k] = 1'b0; m_sel[k] = 1'b0; m_wen[k] = 1'b0;
      m_addr[k] = '0; m_data[k] = '0; m_cnt[k] = 0;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk({nm[k], " wr_en"},   64'(o_wen[k]),  64'(m_wen[k]));
      chk({nm[k], " sel"},     64'(o_sel[k]),  64'(m_sel[k]));
      chk({nm[k], " wr_addr"}, 64'(o_addr[k]), 64'(m_addr[k]));
      chk({nm[k], " wr_data"}, 64'(o_data[k]), 64'(m_data[k]));
      chk({nm[k], " cnt"},     64'(o_cnt[k]),  64'(m_cnt[k]));
    end
  endtask

  // Inputs are set just after a rising edge; readies checked mid-cycle,
  // registered outputs 1 time unit after the next rising edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      gsave[k] = winner(k);
      chk({nm[k], " a_ready"}, 64'(o_ar[k]), 64'(gsave[k] == 1));
      chk({nm[k], " b_ready"}, 64'(o_br[k]), 64'(gsave[k] == 2));
    end
    ra = rr_ar; rb = rr_br;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (gsave[k] != 0) begin
        m_last_a[k] = (gsave[k] == 1);
        m_sel[k]    = (gsave[k] == 1);
        m_addr[k]   = (gsave[k] == 1) ? ard : brd;
        m_data[k]   = (gsave[k] == 1) ? ad : bd;
        m_wen[k]    = (m_addr[k] != 0);
      end else m_wen[k] = 1'b0;
      if (clr) m_cnt[k] = 0;
      else if (av && bv && m_cnt[k] < cmax[k]) m_cnt[k]++;
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();          // outputs must clear without waiting for a clock
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic a, input logic [4:0] ar, input logic [31:0] adt,
                        input logic b, input logic [4:0] br, input logic [31:0] bdt, input logic c);
    av = a; ard = ar; ad = adt; bv = b; brd = br; bd = bdt; clr = c;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic bv; logic [4:0] brd; logic [31:0] bd; logic clr;
    logic e_ar, e_br, e_wen, e_sel; logic [4:0] e_addr; logic [31:0] e_data; logic [3:0] e_cnt;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // expectations for the round-robin instance, starting from reset
    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 1, 0, 1, 1, 5, 32'hDEADBEEF, 0};
    vecs[1] = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 0, 1, 1, 0, 7, 32'h22, 1};
    vecs[2] = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 1, 0, 1, 1, 3, 32'h11, 2};
    vecs[3] = '{0, 0, 0,            1, 0, 32'hFFFF,     0, 0, 1, 0, 0, 0, 32'hFFFF, 2};
    vecs[4] = '{0, 9, 32'h1,        0, 9, 32'h2,        0, 0, 0, 0, 0, 0, 32'hFFFF, 2};
    vecs[5] = '{1, 3, 32'h11,       1, 7, 32'h22,       1, 1, 0, 1, 1, 3, 32'h11, 0};
    vecs[6] = '{1, 0, 32'h5,        0, 4, 32'h6,        0, 1, 0, 0, 1, 0, 32'h5, 0};
    vecs[7] = '{0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 1, 0, 32'h5, 0};

    model_reset();
    do_reset();

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle wr_en", 64'(rr_wen), 0);
      chk("idle sel", 64'(rr_sel), 0);
      chk("idle cnt", 64'(rr_cnt), 0);
    end

    // table vectors
    do_reset();
    foreach (vecs[i]) begin
      set_in(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd, vecs[i].clr);
      cycle();
      chk($sformatf("vec%0d a_ready", i), 64'(ra), 64'(vecs[i].e_ar));
      chk($sformatf("vec%0d b_ready", i), 64'(rb), 64'(vecs[i].e_br));
      chk($sformatf("vec%0d wr_en", i), 64'(rr_wen), 64'(vecs[i].e_wen));
      chk($sformatf("vec%0d sel", i), 64'(rr_sel), 64'(vecs[i].e_sel));
      chk($sformatf("vec%0d wr_addr", i), 64'(rr_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d wr_data", i), 64'(rr_data), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d cnt", i), 64'(rr_cnt), 64'(vecs[i].e_cnt));
    end

    // held conflict from reset: rr alternates A,B,..; fp starves B; counters
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    set_in(1, 3, 32'h11, 1, 7, 32'h22, 0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk($sformatf("alt%0d rr a_ready", i), 64'(ra), 64'(i % 2 == 0));
      chk($sformatf("alt%0d rr sel", i), 64'(rr_sel), 64'(i % 2 == 0));
      chk($sformatf("alt%0d rr wr_addr", i), 64'(rr_addr), (i % 2 == 0) ? 64'd3 : 64'd7);
      chk($sformatf("alt%0d fp b_ready", i), 64'(fp_br), 0);
      chk($sformatf("alt%0d fp cnt", i), 64'(fp_cnt), 64'(i + 1));
    end
    chk("rr cnt saturated", 64'(rr_cnt), 15);
    clr = 1'b1;
    cycle();
    chk("clr rr cnt", 64'(rr_cnt), 0);
    chk("clr fp cnt", 64'(fp_cnt), 0);
    clr = 1'b0;
    cycle();
    chk("post clr rr cnt", 64'(rr_cnt), 1);

    // reset in the middle of traffic
    do_reset();
    chk("mid reset rr wr_en", 64'(rr_wen), 0);
    cycle();
    chk("after reset A first", 64'(ra), 1);

    // randomized traffic; the rr-side requesters hold until accepted
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    ra = 1'b1; rb = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!av || ra) begin
        av = ($urandom_range(0, 3) != 0);
        ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = $urandom;
      end
      if (!bv || rb) begin
        bv = ($urandom_range(0, 2) != 0);
        brd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bd = $urandom;
      end
      clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
